div_seq: RTL and testbench

Sequential unsigned restoring divider for the FPGA controller ALU. It computes `q = a / b` and `r = a % b` using one quotient bit per clock. The flag set (Z/N/C/V) has the same positions and meaning as the combinational multiplier's, so the ALU flag mux takes either unit unchanged. A start/busy/done handshake lets the controller FSM stall while a division is in progress.

---
 rtl/div_seq.sv | 194 +++++++++++++++++++
 tb/tb_div_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq : sequential unsigned restoring divider, one quotient bit per clock.
//
// Computes q = a / b and r = a % b. Flags use the same positions and meaning
// as the combinational multiplier, so the ALU flag mux can take either unit.
// A start/busy/done handshake lets the controller stall while a divide runs.
//
// Parameters
//   WIDTH  operand, quotient and remainder width in bits (>= 2)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request a division (accepted in IDLE or DONE)
//   a      in   dividend, captured on accept
//   b      in   divisor, captured on accept
//   q      out  quotient (registered)
//   r      out  remainder (registered; tied to 0 without DIV_REM_EN)
//   busy   out  high while iterating
//   done   out  one-cycle pulse when q, r and flags are valid
//   Z      out  quotient is zero
//   N      out  quotient MSB
//   C      out  remainder non-zero (tied to 0 without DIV_REM_EN)
//   V      out  divide by zero
//
// Build option
//   DIV_REM_EN  when defined, the remainder register and C flag are built.

module div_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] dvs, dvs_nx;       // latched divisor
  logic [WIDTH-1:0] dvd, dvd_nx;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] prem, prem_nx;     // stored partial remainder
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] q_nx;
  logic             z_nx, n_nx, v_nx;
  logic             busy_nx, done_nx;

  logic [WIDTH:0]   prem_sh;
  logic [WIDTH-1:0] prem_diff;
  logic             qbit;

`ifdef DIV_REM_EN
  logic [WIDTH-1:0] r_nx;
  logic             c_nx;
`endif

  // After every step the partial remainder is below the divisor, so only
  // WIDTH bits need storing; the (WIDTH+1)-bit value exists only transiently
  // as the shifted trial value. When the trial value is >= divisor the
  // difference is < divisor, so a WIDTH-bit subtraction is exact.
  always_comb begin
    prem_sh   = {prem, dvd[WIDTH-1]};
    qbit      = (prem_sh >= {1'b0, dvs});
    prem_diff = prem_sh[WIDTH-1:0] - dvs;
  end

  always_comb begin
    state_nx = state;
    dvs_nx   = dvs;
    dvd_nx   = dvd;
    prem_nx  = prem;
    cnt_nx   = cnt;
    q_nx     = q;
    z_nx     = Z;
    n_nx     = N;
    v_nx     = V;
`ifdef DIV_REM_EN
    r_nx     = r;
    c_nx     = C;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (b != '0) begin
            dvs_nx   = b;
            dvd_nx   = a;
            prem_nx  = '0;
            cnt_nx   = CW'(WIDTH);
            state_nx = RUN;
          end else begin
            q_nx     = '1;
            z_nx     = 1'b0;
            n_nx     = 1'b1;
            v_nx     = 1'b1;
`ifdef DIV_REM_EN
            r_nx     = a;
            c_nx     = (a != '0);
`endif
            state_nx = DONE;
          end
        end else begin
          state_nx = IDLE;
        end
      end

      RUN: begin
        prem_nx   = qbit ? prem_diff : prem_sh[WIDTH-1:0];
        dvd_nx    = dvd << 1;
        dvd_nx[0] = qbit;
        cnt_nx    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          q_nx     = dvd_nx;
          z_nx     = (dvd_nx == '0);
          n_nx     = dvd_nx[WIDTH-1];
          v_nx     = 1'b0;
`ifdef DIV_REM_EN
          r_nx     = prem_nx;
          c_nx     = (prem_nx != '0);
`endif
          state_nx = DONE;
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvs  <= '0;
      dvd  <= '0;
      prem <= '0;
      cnt  <= '0;
      q    <= '0;
      Z    <= 1'b1;
      N    <= 1'b0;
      V    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      dvs  <= dvs_nx;
      dvd  <= dvd_nx;
      prem <= prem_nx;
      cnt  <= cnt_nx;
      q    <= q_nx;
      Z    <= z_nx;
      N    <= n_nx;
      V    <= v_nx;
      busy <= busy_nx;
      done <= done_nx;
    end
  end

`ifdef DIV_REM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
      C <= 1'b0;
    end else begin
      r <= r_nx;
      C <= c_nx;
    end
  end
`else
  assign r = '0;
  assign C = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic [3:0] q, r;
  logic       busy, done, Z, N, C, V;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [3:0]  prev_q  = 4'd0;

  div_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .Z     (Z),
    .N     (N),
    .C     (C),
    .V     (V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] eq;
    logic [3:0] er;
    logic       ez, en, ec, ev;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [3:0] rem_exp(input logic [3:0] v);
`ifdef DIV_REM_EN
    return v;
`else
    return 4'd0 & v;
`endif
  endfunction

  function automatic logic c_exp(input logic v);
`ifdef DIV_REM_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".q"},    32'(q),    32'd0);
    chk({nm, ".r"},    32'(r),    32'd0);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".done"}, 32'(done), 32'd0);
    chk({nm, ".Z"},    32'(Z),    32'd1);
    chk({nm, ".N"},    32'(N),    32'd0);
    chk({nm, ".C"},    32'(C),    32'd0);
    chk({nm, ".V"},    32'(V),    32'd0);
  endtask

  // Starts an operation in the current cycle and checks busy/done every cycle
  // up to and including the done cycle; returns positioned in the done cycle.
  task automatic run_op(input string nm, input vec_t v);
    int unsigned lat;
    lat   = (v.b != 4'd0) ? 5 : 1;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned c = 1; c <= lat; c++) begin
      if (c < lat) begin
        chk($sformatf("%s.busy_c%0d", nm, c), 32'(busy), 32'd1);
        chk($sformatf("%s.done_c%0d", nm, c), 32'(done), 32'd0);
        if (c == 1) chk($sformatf("%s.q_hold", nm), 32'(q), 32'(prev_q));
        tick();
      end else begin
        chk({nm, ".busy_done"}, 32'(busy), 32'd0);
        chk({nm, ".done"},      32'(done), 32'd1);
        chk({nm, ".q"},         32'(q),    32'(v.eq));
        chk({nm, ".r"},         32'(r),    32'(rem_exp(v.er)));
        chk({nm, ".Z"},         32'(Z),    32'(v.ez));
        chk({nm, ".N"},         32'(N),    32'(v.en));
        chk({nm, ".C"},         32'(C),    32'(c_exp(v.ec)));
        chk({nm, ".V"},         32'(V),    32'(v.ev));
      end
    end
    prev_q = v.eq;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //              a      b      q      r      Z     N     C     V
    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'd8,  4'd8,  4'd1,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{4'd14, 4'd3,  4'd4,  4'd2, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
      tick();
      chk($sformatf("vec%0d.idle_done", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d.idle_busy", i), 32'(busy), 32'd0);
    end

    // Start during RUN is ignored, then back-to-back start in the DONE cycle.
    a = 4'd12; b = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd9; b = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign.busy_c3", 32'(busy), 32'd1);
    tick();
    tick();
    chk("ign.done", 32'(done), 32'd1);
    chk("ign.q",    32'(q),    32'd3);
    chk("ign.r",    32'(r),    32'd0);
    chk("ign.C",    32'(C),    32'd0);
    prev_q = 4'd3;
    v = '{4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    run_op("b2b", v);
    tick();

    // Reset mid-operation, asserted together with start.
    a = 4'd13; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0; start = 1'b1; a = 4'd6; b = 4'd4;
    tick();
    chk_reset_vals("midrst");
    rst_n = 1'b1; start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("midrst.no_done%0d", k), 32'(done), 32'd0);
      chk($sformatf("midrst.no_busy%0d", k), 32'(busy), 32'd0);
    end
    prev_q = 4'd0;
    v = '{4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    run_op("after_rst", v);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
